// File: rtl/tfe_pkg.sv
// Shared types and constants for the 2048 move sequencer: direction and state
// encodings, exponent limits, LFSR taps and the line-to-cell index mapping.
package tfe_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // NEWG is reserved in the encoding; a new game clears in IDLE and goes straight to SPAWN.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NEWG  = 3'd1,
    ST_MERGE = 3'd2,
    ST_SPAWN = 3'd3,
    ST_CHECK = 3'd4,
    ST_DUMP  = 3'd5
  } state_e;

  localparam logic [3:0]  EMPTY_EXP = 4'd0;
  localparam logic [3:0]  WIN_EXP   = 4'd11;
  localparam logic [3:0]  MAX_EXP   = 4'd15;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Cell index (4r + c) of element j of line i, gathered toward the move direction.
  function automatic logic [3:0] cell_idx(input dir_e dir, input logic [1:0] line,
                                          input logic [1:0] j);
    logic [1:0] r;
    logic [1:0] c;
    case (dir)
      DIR_LEFT:  begin r = line;      c = j;         end
      DIR_RIGHT: begin r = line;      c = 2'd3 - j;  end
      DIR_UP:    begin r = j;         c = line;      end
      default:   begin r = 2'd3 - j;  c = line;      end
    endcase
    return {r, c};
  endfunction

endpackage

// File: rtl/tfe_line_merge.sv
// Combinational 2048 line merge: compacts toward element 0, merges equal pairs
// once each, reports points gained, whether the line changed and a 2048 merge.
module tfe_line_merge
  import tfe_pkg::*;
(
  input  logic [15:0] line_i,
  output logic [15:0] line_o,
  output logic [16:0] points_o,
  output logic        changed_o,
  output logic        win_o
);

  always_comb begin
    logic [3:0] comp [5];
    logic [3:0] outc [4];
    logic [2:0] k;
    logic       skip;
    for (int j = 0; j < 5; j++) comp[j] = EMPTY_EXP;
    for (int j = 0; j < 4; j++) outc[j] = EMPTY_EXP;
    k        = '0;
    skip     = 1'b0;
    points_o = '0;
    win_o    = 1'b0;

    for (int j = 0; j < 4; j++) begin
      if (line_i[4*j +: 4] != EMPTY_EXP) begin
        comp[k] = line_i[4*j +: 4];
        k       = k + 3'd1;
      end
    end

    // comp[4] stays empty, so the last element never finds a partner.
    k = '0;
    for (int j = 0; j < 4; j++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[j] != EMPTY_EXP) begin
        if (comp[j] == comp[j+1] && comp[j] != MAX_EXP) begin
          outc[k[1:0]] = comp[j] + 4'd1;
          points_o     = points_o + (17'd1 << (comp[j] + 4'd1));
          if (comp[j] + 4'd1 == WIN_EXP) win_o = 1'b1;
          skip = 1'b1;
        end else begin
          outc[k[1:0]] = comp[j];
        end
        k = k + 3'd1;
      end
    end

    line_o    = {outc[3], outc[2], outc[1], outc[0]};
    changed_o = (line_o != line_i);
  end

endmodule

// File: rtl/tfe_move_sequencer.sv
// 2048 move sequencer: holds the board, merges one line per cycle through a
// shared line-merge datapath, spawns tiles from an LFSR and hands off a dump.
module tfe_move_sequencer
  import tfe_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // producers hold valid and payload stable until then, ready never depends on valid.
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_dir,
  output logic        cmd_ready,
  input  logic        new_game,
  output logic [63:0] board,
  output logic [19:0] score,
  output logic        won,
  output logic        lost,
  output logic        dump_valid,
  input  logic        dump_ready,
  input  logic        dbg_load,
  input  logic [63:0] dbg_board,
  output logic [2:0]  dbg_state
);

  state_e      state_q, state_d;
  logic [63:0] board_q, board_d;
  logic [19:0] score_q, score_d;
  logic        won_q, won_d;
  logic        lost_q, lost_d;
  dir_e        dir_q, dir_d;
  logic [1:0]  line_q, line_d;
  logic        moved_q, moved_d;
  logic [1:0]  spawn_cnt_q, spawn_cnt_d;
  logic [3:0]  scan_idx_q, scan_idx_d;
  logic [3:0]  scan_n_q, scan_n_d;
  logic [15:0] lfsr_q, lfsr_d;

  logic [15:0] line_in;
  logic [15:0] line_out;
  logic [16:0] points;
  logic        changed;
  logic        merge_win;
  logic        no_moves;
  logic [20:0] score_sum;

  tfe_line_merge u_merge (
    .line_i    (line_in),
    .line_o    (line_out),
    .points_o  (points),
    .changed_o (changed),
    .win_o     (merge_win)
  );

  always_comb begin
    line_in = '0;
    for (int j = 0; j < 4; j++)
      line_in[4*j +: 4] = board_q[{cell_idx(dir_q, line_q, 2'(j)), 2'b00} +: 4];
  end

  always_comb begin
    no_moves = 1'b1;
    for (int k = 0; k < 16; k++)
      if (board_q[4*k +: 4] == EMPTY_EXP) no_moves = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (board_q[4*(4*r+c) +: 4] == board_q[4*(4*r+c+1) +: 4]) no_moves = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (board_q[4*(4*r+c) +: 4] == board_q[4*(4*r+c+4) +: 4]) no_moves = 1'b0;
  end

  assign lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign score_sum = {1'b0, score_q} + {4'b0, points};

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    score_d     = score_q;
    won_d       = won_q;
    lost_d      = lost_q;
    dir_d       = dir_q;
    line_d      = line_q;
    moved_d     = moved_q;
    spawn_cnt_d = spawn_cnt_q;
    scan_idx_d  = scan_idx_q;
    scan_n_d    = scan_n_q;
    cmd_ready   = 1'b0;
    dump_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = !lost_q && !dbg_load;
        if (new_game) begin
          board_d     = '0;
          score_d     = '0;
          won_d       = 1'b0;
          lost_d      = 1'b0;
          spawn_cnt_d = 2'd2;
          scan_idx_d  = lfsr_q[3:0];
          scan_n_d    = '0;
          state_d     = ST_SPAWN;
        end else if (dbg_load) begin
          board_d = dbg_board;
          lost_d  = 1'b0;
        end else if (cmd_valid && !lost_q) begin
          dir_d   = dir_e'(cmd_dir);
          moved_d = 1'b0;
          line_d  = '0;
          state_d = ST_MERGE;
        end
      end

      ST_MERGE: begin
        for (int j = 0; j < 4; j++)
          board_d[{cell_idx(dir_q, line_q, 2'(j)), 2'b00} +: 4] = line_out[4*j +: 4];
        score_d = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
        moved_d = moved_q | changed;
        if (merge_win) won_d = 1'b1;
        line_d = line_q + 2'd1;
        if (line_q == 2'd3) begin
          if (moved_q | changed) begin
            spawn_cnt_d = 2'd1;
            scan_idx_d  = lfsr_q[3:0];
            scan_n_d    = '0;
            state_d     = ST_SPAWN;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_SPAWN: begin
        if (board_q[{scan_idx_q, 2'b00} +: 4] == EMPTY_EXP) begin
          board_d[{scan_idx_q, 2'b00} +: 4] = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
          spawn_cnt_d = spawn_cnt_q - 2'd1;
          if (spawn_cnt_q == 2'd1) begin
            state_d = ST_CHECK;
          end else begin
            scan_idx_d = lfsr_q[3:0];
            scan_n_d   = '0;
          end
        end else if (scan_n_q == 4'd15) begin
          state_d = ST_CHECK;
        end else begin
          scan_idx_d = scan_idx_q + 4'd1;
          scan_n_d   = scan_n_q + 4'd1;
        end
      end

      ST_CHECK: begin
        lost_d  = no_moves;
        state_d = ST_DUMP;
      end

      ST_DUMP: begin
        dump_valid = 1'b1;
        if (dump_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      board_q     <= '0;
      score_q     <= '0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
      dir_q       <= DIR_UP;
      line_q      <= '0;
      moved_q     <= 1'b0;
      spawn_cnt_q <= '0;
      scan_idx_q  <= '0;
      scan_n_q    <= '0;
      lfsr_q      <= SEED;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      score_q     <= score_d;
      won_q       <= won_d;
      lost_q      <= lost_d;
      dir_q       <= dir_d;
      line_q      <= line_d;
      moved_q     <= moved_d;
      spawn_cnt_q <= spawn_cnt_d;
      scan_idx_q  <= scan_idx_d;
      scan_n_q    <= scan_n_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign board     = board_q;
  assign score     = score_q;
  assign won       = won_q;
  assign lost      = lost_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tfe_move_sequencer.sv
// Directed bench for tfe_move_sequencer: a table of preload/move vectors plus
// hand-written sequences for reset, latency, loss, contention and mid-move reset.
module tb_tfe_move_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_dir;
  logic        cmd_ready;
  logic        new_game;
  logic [63:0] board;
  logic [19:0] score;
  logic        won;
  logic        lost;
  logic        dump_valid;
  logic        dump_ready;
  logic        dbg_load;
  logic [63:0] dbg_board;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [19:0] exp_score;

  typedef struct {
    logic [1:0]  dir;
    logic [63:0] bin;
    logic [63:0] bexp;
    int          pts;
    bit          moved;
    bit          won;
  } vec_t;

  vec_t vecs [7];
  vec_t v;

  tfe_move_sequencer #(.SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_dir    (cmd_dir),
    .cmd_ready  (cmd_ready),
    .new_game   (new_game),
    .board      (board),
    .score      (score),
    .won        (won),
    .lost       (lost),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dbg_load   (dbg_load),
    .dbg_board  (dbg_board),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int count_nz(input logic [63:0] b);
    int n = 0;
    for (int k = 0; k < 16; k++) if (b[4*k +: 4] != 4'd0) n++;
    return n;
  endfunction

  function automatic logic [63:0] nz_mask(input logic [63:0] b);
    logic [63:0] m = '0;
    for (int k = 0; k < 16; k++) if (b[4*k +: 4] != 4'd0) m[4*k +: 4] = 4'hF;
    return m;
  endfunction

  // Nonzero cells outside the mask whose value is not a legal spawn (1 or 2).
  function automatic int count_bad_spawn(input logic [63:0] b, input logic [63:0] m);
    int n = 0;
    for (int k = 0; k < 16; k++)
      if (m[4*k +: 4] == 4'h0 && b[4*k +: 4] != 4'd0 &&
          b[4*k +: 4] != 4'd1 && b[4*k +: 4] != 4'd2) n++;
    return n;
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_board(input logic [63:0] b);
    @(negedge clk);
    dbg_load  = 1'b1;
    dbg_board = b;
    @(negedge clk);
    dbg_load  = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic wait_dump(output int cyc);
    cyc = 0;
    while (!dump_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic finish_dump();
    @(negedge clk);
    dump_ready = 1'b1;
    @(negedge clk);
    dump_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int viol;
    logic [63:0] mask;
    logic [63:0] snap;

    rst = 1'b0; cmd_valid = 1'b0; cmd_dir = 2'b00; new_game = 1'b0;
    dump_ready = 1'b0; dbg_load = 1'b0; dbg_board = '0;

    //                 dir    board in                 expected (spawn excluded)  pts  mv won
    vecs[0] = '{2'b10, 64'h0000_0000_0000_1111, 64'h0000_0000_0000_0022, 8,    1'b1, 1'b0};
    vecs[1] = '{2'b11, 64'h0000_0000_0000_0211, 64'h0000_0000_0000_2200, 4,    1'b1, 1'b0};
    vecs[2] = '{2'b00, 64'h0003_0001_0000_0001, 64'h0000_0000_0003_0002, 4,    1'b1, 1'b0};
    vecs[3] = '{2'b01, 64'h0000_0020_0020_0020, 64'h0030_0020_0000_0000, 8,    1'b1, 1'b0};
    vecs[4] = '{2'b10, 64'h0000_0000_0000_4321, 64'h0000_0000_0000_4321, 0,    1'b0, 1'b0};
    vecs[5] = '{2'b10, 64'h0000_0000_1000_00FF, 64'h0000_0000_0001_00FF, 0,    1'b1, 1'b0};
    vecs[6] = '{2'b11, 64'h0000_0AA0_0000_0000, 64'h0000_B000_0000_0000, 2048, 1'b1, 1'b1};

    // reset state
    do_reset();
    check("rst_board", board, 64'h0);
    check("rst_score", {44'h0, score}, 64'h0);
    check("rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    check("rst_dump_valid", {63'h0, dump_valid}, 64'h0);
    check("rst_won_lost", {62'h0, won, lost}, 64'h0);

    // new game spawns exactly two tiles of exponent 1 or 2
    pulse_new_game();
    wait_dump(cyc);
    check("ng_dump_valid", {63'h0, dump_valid}, 64'h1);
    check("ng_tile_count", count_nz(board), 2);
    check("ng_tile_values", count_bad_spawn(board, 64'h0), 0);
    finish_dump();
    exp_score = '0;

    // table-driven moves
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      exp_score = exp_score + 20'(v.pts);
      exp_q.push_back({44'h0, exp_score});
      load_board(v.bin);
      send_cmd(v.dir);
      wait_dump(cyc);
      check("vec_dump_valid", {63'h0, dump_valid}, 64'h1);
      mask = nz_mask(v.bexp);
      check("vec_cells", board & mask, v.bexp);
      check("vec_spawn_count", count_nz(board & ~mask), v.moved ? 64'd1 : 64'd0);
      check("vec_spawn_value", count_bad_spawn(board, mask), 0);
      check("vec_score", {44'h0, score}, exp_q.pop_front());
      check("vec_won", {63'h0, won}, {63'h0, v.won});
      finish_dump();
      check("vec_ready_after", {63'h0, cmd_ready}, 64'h1);
    end

    // no-move latency: 5 cycles from acceptance to dump_valid, board untouched
    load_board(64'h0000_0000_0000_4321);
    send_cmd(2'b10);
    wait_dump(cyc);
    check("nomove_latency", cyc, 5);
    check("nomove_board", board, 64'h0000_0000_0000_4321);
    check("nomove_score", {44'h0, score}, {44'h0, exp_score});
    finish_dump();

    // loss: only row 0 can shift right, leaving cell 0 for the spawn
    load_board(64'h3434_4343_3434_0434);
    send_cmd(2'b11);
    wait_dump(cyc);
    check("loss_board", board & 64'hFFFF_FFFF_FFFF_FFF0, 64'h3434_4343_3434_4340);
    check("loss_spawn_value", count_bad_spawn(board, 64'hFFFF_FFFF_FFFF_FFF0), 0);
    check("loss_spawn_count", count_nz(board), 16);
    check("loss_lost", {63'h0, lost}, 64'h1);
    finish_dump();
    check("loss_cmd_ready", {63'h0, cmd_ready}, 64'h0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = 2'b10;
    repeat (5) @(negedge clk);
    check("loss_cmd_ignored", {61'h0, dbg_state}, 64'h0);
    check("loss_ready_held", {63'h0, cmd_ready}, 64'h0);
    cmd_valid = 1'b0;
    pulse_new_game();
    wait_dump(cyc);
    check("loss_ng_lost", {63'h0, lost}, 64'h0);
    check("loss_ng_won", {63'h0, won}, 64'h0);
    check("loss_ng_score", {44'h0, score}, 64'h0);
    finish_dump();
    check("loss_ng_ready", {63'h0, cmd_ready}, 64'h1);

    // contention and backpressure
    load_board(64'h0000_0000_0000_1111);
    @(negedge clk);
    new_game  = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir   = 2'b10;
    @(negedge clk);
    new_game = 1'b0;
    check("cont_board_cleared", board, 64'h0);
    check("cont_state_spawn", {61'h0, dbg_state}, 64'd3);
    wait_dump(cyc);
    check("cont_dump_valid", {63'h0, dump_valid}, 64'h1);
    check("cont_tile_count", count_nz(board), 2);
    snap = board;
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (!dump_valid || board !== snap || cmd_ready) viol++;
    end
    check("cont_backpressure", viol, 0);
    cmd_valid = 1'b0;
    finish_dump();
    check("cont_released", {63'h0, dump_valid}, 64'h0);
    check("cont_idle", {61'h0, dbg_state}, 64'h0);

    // reset in the middle of a move abandons it with no dump
    load_board(64'h0000_0000_0000_1111);
    send_cmd(2'b10);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_board", board, 64'h0);
    check("midrst_state", {61'h0, dbg_state}, 64'h0);
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (dump_valid) viol++;
    end
    check("midrst_no_dump", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tfe_move_sequencer.md
# tfe_move_sequencer

Sequences the 2048 game datapath: accepts a move command, holds the 4×4 board, and drives one shared line-merge datapath over the four lines of the move, one line per cycle. After a move it spawns a new tile from an LFSR, updates score, win and loss flags, and hands the board to the UART printer through a valid/ready handshake. It sits between the button/UART command decoder and the board-dump transmitter in the TwentyFortyEight top level.

## Interface
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-low reset.
- `cmd_valid`  in  1: move command present.
- `cmd_dir`  in  2: move direction. 00 = up, 01 = down, 10 = left, 11 = right.
- `cmd_ready`  out  1: sequencer accepts a command this cycle.
- `new_game`  in  1: single-cycle pulse that starts a new game. Sampled only in IDLE.
- `board`  out  64: cell k (k = 4r + c) occupies bits [4k+3:4k]. Each cell holds an exponent; 0 means empty, e means tile value 2^e.
- `score`  out  20: running score; saturates at 20'hFFFFF.
- `won`  out  1: sticky; set when a merge produces exponent 11 (the 2048 tile).
- `lost`  out  1: no empty cell and no equal orthogonal neighbours.
- `dump_valid`  out  1: board and score are ready to print.
- `dump_ready`  in  1: printer accepts the dump.

## Operation
- **States:** IDLE, NEWG, MERGE, SPAWN, CHECK, DUMP.
- **IDLE**
  - `cmd_ready` = !`lost`.
  - `new_game` has priority over `cmd_valid` in the same cycle.
  - On `new_game`: clear board, score, `won` and `lost`; spawn count = 2; go to SPAWN.
  - On `cmd_valid` && `cmd_ready`: latch `cmd_dir`, clear the moved flag, set line = 0, go to MERGE.
- **MERGE** runs 4 cycles, one per line i. Line element j is gathered toward the move direction:
  - left: (r=i, c=j)
  - right: (r=i, c=3−j)
  - up: (r=j, c=i)
  - down: (r=3−j, c=i)
- **line_merge rules**
  - Compact nonzero cells toward j = 0.
  - Merge equal adjacent pairs once each, scanning from j = 0; a merged pair becomes e+1.
  - Cells with exponent 15 never merge.
  - Output the merged line, the points gained (sum of 2^(e+1) over merges) and a changed bit.
- **MERGE writeback**
  - Write the merged line back each cycle and add the points gained to score (saturating).
  - OR the changed bit into the moved flag. Set `won` if any merge yields 11.
  - After line 3: if moved, spawn count = 1 and go to SPAWN; otherwise go to CHECK.
- **SPAWN**
  - On entry, start index = `lfsr[3:0]`; scan one cell per cycle, index +1 mod 16.
  - Write exponent 2 into the first empty cell found if `lfsr[7:4]` == 0, else exponent 1.
  - Decrement the spawn count; restart the scan while the count is nonzero.
  - If 16 cells are scanned with no empty cell, abandon the spawn and go to CHECK.
- **CHECK** (1 cycle): compute `lost` combinationally from the board, register it, go to DUMP.
- **DUMP**
  - `dump_valid` = 1; board and score are frozen.
  - On `dump_valid` && `dump_ready`, go to IDLE.
- **LFSR:** 16-bit Galois, taps x^16 + x^14 + x^13 + x^11. It advances every cycle regardless of state.
- **Reset:** board 0, score 0, `won` 0, `lost` 0, `dump_valid` 0, `cmd_ready` 1, lfsr = `SEED`, state IDLE. Reset mid-operation abandons the move with no partial dump.

## Timing
- Command accepted at edge T0. MERGE writes lines 0..3 at T1..T4.
- No-move path: CHECK at T5; `dump_valid` high from T5 until the handshake.
- Move path: SPAWN takes 1..16 cycles, then CHECK, then DUMP. Best case, `dump_valid` rises after T6.
- New game: two spawn scans (2..32 cycles), CHECK, then DUMP.
- `cmd_ready` is 0 in every state except IDLE. A command presented outside IDLE is not consumed; the producer holds it.
- `dump_valid` stays asserted until `dump_ready`. The board does not change while `dump_valid` = 1.
- `score`, `won` and `lost` are registered outputs, updated on the edge that writes the board.

## Structure
- **Package `tfe_pkg`:**
  - direction encodings
  - state enum
  - EMPTY_EXP = 0, WIN_EXP = 11, MAX_EXP = 15
  - LFSR tap mask
  - cell-index helper function
- **Sub-module `tfe_line_merge`:** combinational. Input: four 4-bit exponents. Outputs: four 4-bit exponents, 17-bit points, changed.
- **Sequencer contents:** FSM, board register, line gather/scatter muxing, LFSR, spawn scanner, loss checker.

## Test plan
- **Reset:** hold `rst` = 0 for 2 cycles, release. Board = 0, score = 0, `cmd_ready` = 1, `dump_valid` = 0. `new_game` then yields exactly 2 nonzero cells, each 1 or 2, and `dump_valid` rises.
- **Left merge:** preload row 0 = [1,1,1,1] with all else empty, command left. Row 0 = [2,2,_,_] plus one spawned tile elsewhere in rows 1–3 or row 0 cols 2–3; score += 8.
- **No move:** board with row 0 = [1,2,3,4] only, command left. Board unchanged, no spawn, one dump, latency 5 cycles to `dump_valid`.
- **Win:** preload two adjacent exponent-10 cells in a row, command toward them. Exponent 11 appears, `won` = 1, score += 2048.
- **Loss:** preload a checkerboard of 1/2 with one empty cell such that after move and spawn no merges remain. `lost` = 1 and `cmd_ready` stays 0. `new_game` clears it.
- **Contention and backpressure:** hold `dump_ready` = 0 for 50 cycles, with `cmd_valid` and `new_game` asserted together in IDLE. `new_game` wins; `dump_valid` stays high and the board is stable until `dump_ready` = 1.
